// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Holds the scan FSM encoding, the hex glyph table and a width helper.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } scan_state_e;

    // Active-high glyphs for 0..F, segment a on bit 6 through g on bit 0.
    localparam logic [6:0] SegTable [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Bits needed to hold 0..value-1; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module hex_seg_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SegTable[nib_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner with double-buffered digit data,
// blanking gaps between digits, leading-zero suppression and output polarity.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          AN_ACT_LOW  = 1'b1,
    parameter bit          LZ_EN       = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*NDIG-1:0]   data_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blank_in,
    output logic [6:0]          seg_out,
    output logic                dp_out,
    output logic [NDIG-1:0]     an_out,
    output logic                frame_done
);

    // One counter serves both the lit and the blank phase.
    localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int unsigned CntW   = clog2(CntMax);
    localparam int unsigned IdxW   = clog2(NDIG);

    localparam logic [CntW-1:0] ShowLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(BLANK_CYC - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NDIG - 1);

    localparam logic [6:0]      SegOff = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic            DpOff  = SEG_ACT_LOW;
    localparam logic [NDIG-1:0] AnOff  = AN_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

    scan_state_e       state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              armed_q;
    logic              frame_done_q;

    logic [4*NDIG-1:0] pend_data_q, disp_data_q;
    logic [NDIG-1:0]   pend_dp_q, disp_dp_q;
    logic [NDIG-1:0]   pend_blank_q, disp_blank_q;
    logic              pend_flag_q;

    logic [6:0]        seg_q;
    logic              dp_q;
    logic [NDIG-1:0]   an_q;

    logic              frame_end;
    logic              xfer;
    logic [NDIG-1:0]   lz;
    logic              lz_run;
    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank, cur_lz;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_hi;
    logic              dp_hi;
    logic [NDIG-1:0]   an_hi;

    assign frame_end = en && (state_q == StGap) && (cnt_q == GapLast) && (idx_q == IdxLast);
    assign xfer      = pend_flag_q && (frame_end || (state_q == StIdle));

    // armed_q swallows the first edge after reset so no input is sampled on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            armed_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (!armed_q) begin
            armed_q <= 1'b1;
        end else begin
            frame_done_q <= 1'b0;
            if (!en) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StShow;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                    StShow: begin
                        if (cnt_q == ShowLast) begin
                            state_q <= StGap;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StGap: begin
                        if (cnt_q == GapLast) begin
                            state_q      <= StShow;
                            cnt_q        <= '0;
                            idx_q        <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                            frame_done_q <= (idx_q == IdxLast);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    // The display copy reads the old pending set, so a coincident load stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_flag_q  <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
        end else if (armed_q) begin
            if (xfer) begin
                disp_data_q  <= pend_data_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
            end
            if (load) begin
                pend_data_q  <= data_in;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
                pend_flag_q  <= 1'b1;
            end else if (xfer) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        lz     = '0;
        lz_run = LZ_EN;
        for (int k = NDIG - 1; k >= 1; k--) begin
            lz_run = lz_run & (disp_data_q[4*k +: 4] == 4'h0);
            lz[k]  = lz_run;
        end

        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        an_hi     = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_nib   = disp_data_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = disp_blank_q[k];
                cur_lz    = lz[k];
                an_hi[k]  = (state_q == StShow);
            end
        end

        seg_hi = '0;
        dp_hi  = 1'b0;
        if (state_q == StShow && !cur_blank) begin
            seg_hi = cur_lz ? 7'h00 : dec_seg;
            dp_hi  = cur_dp;
        end
    end

    hex_seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // XOR with the off level converts active-high internals to pin polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SegOff;
            dp_q  <= DpOff;
            an_q  <= AnOff;
        end else if (armed_q) begin
            seg_q <= seg_hi ^ SegOff;
            dp_q  <= dp_hi ^ DpOff;
            an_q  <= an_hi ^ AnOff;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule
